fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Sequences the program counter and instruction fetch for the core: owns the fetch PC, issues one request at a time to instruction memory, and delivers each instruction with its PC to decode over a valid/ready handshake. Taken-branch redirects (`PCsrc`, `ImmOp`) reload the PC and squash any wrong-path fetch in flight. It sits between the branch-resolution logic, the instruction memory port and the decode stage.

## Interface
- `PC_WIDTH`, 32, width of PC, immediate and memory address
- `INSTR_WIDTH`, 32, instruction word width
- `RESET_PC`, 0, first fetch address after reset
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `PCsrc`  in  1  one-cycle pulse: branch taken, redirect fetch
- `br_pc`  in  PC_WIDTH  PC of the branching instruction
- `ImmOp`  in  PC_WIDTH  branch offset; target = `br_pc + ImmOp`
- `imem_req`  out  1  fetch request
- `imem_addr`  out  PC_WIDTH  fetch address
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response data valid
- `imem_rdata`  in  INSTR_WIDTH  response instruction
- `instr_valid`  out  1  `instr`/`instr_pc` valid to decode
- `instr_ready`  in  1  decode accepts this cycle
- `instr`  out  INSTR_WIDTH  fetched instruction
- `instr_pc`  out  PC_WIDTH  address of `instr`

## Operation
- States:
  - IDLE: one cycle after reset release.
  - REQ: `imem_req`=1.
  - WAIT: granted, awaiting `imem_rvalid`.
- Registers:
  - `fetch_pc`.
  - `kill`: discard the next response.
  - Output register: `instr`, `instr_pc`, `instr_valid`.
- Transitions:
  - IDLE→REQ unconditionally.
  - REQ→WAIT on `imem_req && imem_gnt`.
  - WAIT→REQ on `imem_rvalid`.
- Request gating: in REQ, `imem_req` is asserted only if the output register is empty or `instr_ready` is high this cycle. Otherwise hold REQ with `imem_req`=0.
- While `imem_req`=1 and not granted, `imem_addr` is held stable, even across a redirect.
- Accepted response (WAIT, `imem_rvalid`, `kill`=0, no `PCsrc`):
  - Load `instr`←`imem_rdata`, `instr_pc`←address of that request, `instr_valid`←1.
  - `fetch_pc`←`fetch_pc+4`, modulo 2^PC_WIDTH. Wrap from all-ones-minus-3 to 0 is legal.
- Redirect (`PCsrc`=1):
  - `fetch_pc`←(`br_pc+ImmOp`) with bits [1:0] forced to 0. Addition is modulo 2^PC_WIDTH; carry-out is dropped.
  - `instr_valid` clears next cycle, even if `instr_ready` is high this cycle. The held instruction is wrong-path.
  - In WAIT without `imem_rvalid`, or in REQ with `imem_gnt`: set `kill`.
  - In REQ without grant: set `kill`, keep the old address until granted, and fetch the target on the next request.
  - In WAIT with `imem_rvalid` the same cycle: the response is dropped and `kill` is not set.
  - Back-to-back redirects: the last one wins.
- Killed response (`imem_rvalid` with `kill`=1): dropped, `kill`←0, `fetch_pc` not incremented, next state REQ.
- Output handshake: `instr_valid` stays high with stable `instr`/`instr_pc` until `instr_valid && instr_ready`. It then clears, unless a new response loads the same cycle.
- `imem_rvalid` outside WAIT is ignored.

## Timing
- Reset (asynchronous assert; release synchronous to `clk`):
  - state IDLE, `fetch_pc`=RESET_PC, `kill`=0.
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `instr_valid`=0, `instr`=0, `instr_pc`=RESET_PC.
- Reset asserted mid-transaction abandons it. Memory must tolerate an orphaned response; responses arriving before the first post-reset grant are ignored.
- `imem_req` and `imem_addr` are combinational from state, `fetch_pc` and `instr_ready` only. There is no path from `imem_gnt` or `imem_rvalid`.
- Latency: `imem_rvalid` in cycle N → `instr_valid`=1 in N+1.
- Best-case throughput is one instruction per 2 cycles: gnt in cycle N, rvalid in N+1, req again in N+2.
- `PCsrc` in cycle N → `instr_valid`=0 in N+1. The first target-path request is issued no earlier than N+1.

## Test plan
- Reset release, immediate `imem_gnt`, `imem_rvalid` one cycle later, `instr_ready`=1:
  - `instr_pc` sequence 0x0, 0x4, 0x8, 0xC.
  - `instr` matches memory.
  - `imem_req` every other cycle.
- Backpressure: `instr_ready`=0 for 5 cycles while holding 0x8:
  - `instr`/`instr_pc` stable.
  - No `imem_req` after the next request completes.
  - Release → 0xC delivered next.
- Redirect in WAIT (`br_pc`=0x10, `ImmOp`=0x20):
  - The in-flight response is dropped.
  - Next `imem_addr`=0x30.
  - Next delivered `instr_pc`=0x30.
- Redirect in REQ with `imem_gnt`=0 for 3 cycles:
  - `imem_addr` stays old until grant.
  - The response is dropped.
  - The following request is to the target.
- `PCsrc` coincident with `imem_rvalid`, and with a held `instr_valid`+`instr_ready`:
  - No instruction delivered.
  - `instr_valid`=0 next cycle.
  - Target fetched.
- Wrap and misaligned target:
  - `fetch_pc`=0xFFFFFFFC → next 0x0.
  - `br_pc`=0x100, `ImmOp`=0xFFFFFF07 → target 0x4.
  - Reset asserted in WAIT → all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: branch redirect, instruction memory port and
// decode-side valid/ready handshake.
//   master : the fetch sequencer (drives imem_req/imem_addr and instr_*)
//   slave  : the surrounding core (branch unit, memory, decode)
interface fetch_sequencer_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   PCsrc;
    logic [PC_WIDTH-1:0]    br_pc;
    logic [PC_WIDTH-1:0]    ImmOp;
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_gnt;
    logic                   imem_rvalid;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    instr_pc;

    modport master (
        input  PCsrc, br_pc, ImmOp, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output PCsrc, br_pc, ImmOp, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, issues one instruction-memory request at
// a time and hands each instruction plus its PC to decode. Taken-branch
// redirects reload the PC and squash any wrong-path fetch in flight.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - fetch_sequencer_if.master (redirect in, imem req/gnt/rvalid,
//          decode instr/instr_pc/valid/ready)
module fetch_sequencer #(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                rst,
    fetch_sequencer_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                 r_state;
    logic [PC_WIDTH-1:0]    r_fetch_pc;
    logic [PC_WIDTH-1:0]    r_req_addr;   // address presented/granted for the current request
    logic                   r_hold;       // request was presented last cycle and not granted
    logic                   r_kill;       // drop the next response
    logic                   r_instr_valid;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]    r_instr_pc;

    logic                   w_req;
    logic [PC_WIDTH-1:0]    w_addr;
    logic [PC_WIDTH-1:0]    w_sum;
    logic [PC_WIDTH-1:0]    w_target;
    logic                   w_resp;
    logic                   w_load;

    // Request path depends only on state, held address, fetch_pc and instr_ready.
    // An ungranted request stays asserted so its address cannot be withdrawn.
    always_comb begin
        w_req    = (r_state == S_REQ) && (r_hold || !r_instr_valid || bus.instr_ready);
        w_addr   = r_hold ? r_req_addr : r_fetch_pc;
        w_sum    = bus.br_pc + bus.ImmOp;
        w_target = {w_sum[PC_WIDTH-1:2], 2'b00};
        w_resp   = (r_state == S_WAIT) && bus.imem_rvalid;
        w_load   = w_resp && !r_kill && !bus.PCsrc;
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = w_addr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;

    // State machine, PC, kill flag and decode output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_hold        <= 1'b0;
            r_kill        <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_REQ;
                S_REQ:   if (w_req && bus.imem_gnt) r_state <= S_WAIT;
                S_WAIT:  if (bus.imem_rvalid) r_state <= S_REQ;
                default: r_state <= S_IDLE;
            endcase

            r_hold <= w_req && !bus.imem_gnt;
            if (w_req) begin
                r_req_addr <= w_addr;
            end

            if (bus.PCsrc) begin
                r_fetch_pc <= w_target;
            end else if (w_load) begin
                r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
            end

            // A redirect kills whatever is or will be outstanding; a response
            // arriving alongside the redirect is simply dropped instead.
            if (w_resp) begin
                r_kill <= 1'b0;
            end else if (bus.PCsrc && ((r_state == S_WAIT) || w_req)) begin
                r_kill <= 1'b1;
            end

            if (w_load) begin
                r_instr_valid <= 1'b1;
                r_instr       <= bus.imem_rdata;
                r_instr_pc    <= r_req_addr;
            end else if (bus.PCsrc || (r_instr_valid && bus.instr_ready)) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory/branch stimulus in one initial
// block, delivered instructions checked against a queue of expected fetches.
module tb_fetch_sequencer;

    localparam int unsigned PW = 32;
    localparam int unsigned IW = 32;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [IW-1:0] ins;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t q[$];

    fetch_sequencer_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();

    fetch_sequencer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem(input logic [PW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Bounded wait for a request, then check its address.
    task automatic wait_req(input logic [PW-1:0] exp_addr);
        int n;
        n = 0;
        #1;
        while (!bus.imem_req && n < 20) begin
            step();
            #1;
            n++;
        end
        chk($sformatf("req_seen@%h", exp_addr), 32'(bus.imem_req), 32'd1);
        chk($sformatf("req_addr@%h", exp_addr), bus.imem_addr, exp_addr);
    endtask

    // One complete fetch: grant immediately, respond the following cycle.
    task automatic do_fetch(input logic [PW-1:0] a, input bit push, input bit ready_in_wait);
        wait_req(a);
        bus.imem_gnt = 1'b1;
        if (push) q.push_back('{pc: a, ins: mem(a)});
        step();
        bus.imem_gnt    = 1'b0;
        bus.instr_ready = ready_in_wait;
        #1;
        chk($sformatf("no_req_in_wait@%h", a), 32'(bus.imem_req), 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem(a);
        step();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        #1;
        chk($sformatf("latency_valid@%h", a), 32'(bus.instr_valid), 32'd1);
    endtask

    // Decode side: every accepted instruction must be the oldest expected one.
    // A handshake coinciding with a redirect is wrong-path and not consumed.
    always @(negedge clk) begin
        if (rst && bus.instr_valid && bus.instr_ready && !bus.PCsrc) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_delivery: observed pc=%h expected none", bus.instr_pc);
            end
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("deliv_pc", bus.instr_pc, e.pc);
                chk("deliv_instr", bus.instr, e.ins);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.PCsrc = 1'b0;
        bus.br_pc = '0;
        bus.ImmOp = '0;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus.instr_ready = 1'b1;

        // Reset values
        #3;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_pc", bus.instr_pc, 32'h0);
        step();
        rst = 1'b1;
        #1;
        chk("idle_no_req", 32'(bus.imem_req), 32'd0);
        step();

        // Straight-line fetch 0x0, 0x4
        do_fetch(32'h0, 1'b1, 1'b1);
        do_fetch(32'h4, 1'b1, 1'b1);

        // Backpressure while holding 0x8
        do_fetch(32'h8, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 32'(bus.instr_valid), 32'd1);
            chk("bp_pc", bus.instr_pc, 32'h8);
            chk("bp_instr", bus.instr, mem(32'h8));
            chk("bp_no_req", 32'(bus.imem_req), 32'd0);
            step();
        end
        bus.instr_ready = 1'b1;
        do_fetch(32'hC, 1'b1, 1'b1);

        // Redirect in WAIT: 0x10 + 0x20
        wait_req(32'h10);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        bus.PCsrc = 1'b1;
        bus.br_pc = 32'h10;
        bus.ImmOp = 32'h20;
        step();
        bus.PCsrc = 1'b0;
        #1;
        chk("redir_wait_valid", 32'(bus.instr_valid), 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = mem(32'h10);
        step();
        bus.imem_rvalid = 1'b0;
        do_fetch(32'h30, 1'b1, 1'b1);
        step();

        // Redirect in REQ with grant withheld for 3 cycles
        wait_req(32'h34);
        bus.PCsrc = 1'b1;
        bus.br_pc = 32'h40;
        bus.ImmOp = 32'h8;
        step();
        bus.PCsrc = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold_req", 32'(bus.imem_req), 32'd1);
            chk("hold_addr", bus.imem_addr, 32'h34);
            step();
        end
        #1;
        chk("hold_addr_gnt", bus.imem_addr, 32'h34);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = mem(32'h34);
        step();
        bus.imem_rvalid = 1'b0;
        do_fetch(32'h48, 1'b1, 1'b1);

        // Redirect coincident with rvalid
        wait_req(32'h4C);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = mem(32'h4C);
        bus.PCsrc = 1'b1;
        bus.br_pc = 32'h200;
        bus.ImmOp = 32'h0;
        step();
        bus.PCsrc = 1'b0;
        bus.imem_rvalid = 1'b0;
        #1;
        chk("coinc_valid", 32'(bus.instr_valid), 32'd0);
        chk("coinc_req", 32'(bus.imem_req), 32'd1);
        chk("coinc_addr", bus.imem_addr, 32'h200);
        do_fetch(32'h200, 1'b1, 1'b1);

        // Redirect while instr_valid held and instr_ready high
        do_fetch(32'h204, 1'b0, 1'b0);
        bus.instr_ready = 1'b1;
        bus.PCsrc = 1'b1;
        bus.br_pc = 32'h300;
        bus.ImmOp = 32'h10;
        #1;
        chk("held_redir_req", 32'(bus.imem_req), 32'd1);
        chk("held_redir_addr", bus.imem_addr, 32'h208);
        step();
        bus.PCsrc = 1'b0;
        #1;
        chk("held_redir_valid", 32'(bus.instr_valid), 32'd0);
        chk("held_redir_hold", bus.imem_addr, 32'h208);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = mem(32'h208);
        step();
        bus.imem_rvalid = 1'b0;
        do_fetch(32'h310, 1'b1, 1'b1);
        step();

        // Redirect in REQ with grant, to the top of the address space, then wrap
        wait_req(32'h314);
        bus.imem_gnt = 1'b1;
        bus.PCsrc = 1'b1;
        bus.br_pc = 32'hFFFF_FFF0;
        bus.ImmOp = 32'hC;
        step();
        bus.imem_gnt = 1'b0;
        bus.PCsrc = 1'b0;
        #1;
        chk("gnt_redir_valid", 32'(bus.instr_valid), 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = mem(32'h314);
        step();
        bus.imem_rvalid = 1'b0;
        do_fetch(32'hFFFF_FFFC, 1'b1, 1'b1);
        do_fetch(32'h0, 1'b1, 1'b1);

        // Misaligned target with carry-out: 0x100 + 0xFFFFFF07 -> 0x4
        wait_req(32'h4);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        bus.PCsrc = 1'b1;
        bus.br_pc = 32'h100;
        bus.ImmOp = 32'hFFFF_FF07;
        step();
        bus.PCsrc = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = mem(32'h4);
        step();
        bus.imem_rvalid = 1'b0;
        do_fetch(32'h4, 1'b1, 1'b1);

        // Reset asserted in WAIT
        wait_req(32'h8);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        #1;
        chk("pre_reset_drained", 32'(q.size()), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
        chk("mid_rst_addr", bus.imem_addr, 32'h0);
        chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("mid_rst_instr", bus.instr, 32'h0);
        chk("mid_rst_pc", bus.instr_pc, 32'h0);
        step();
        rst = 1'b1;
        bus.imem_rvalid = 1'b1;      // orphaned response from the abandoned fetch
        bus.imem_rdata = mem(32'h8);
        step();
        bus.imem_rvalid = 1'b0;
        do_fetch(32'h0, 1'b1, 1'b1);

        repeat (3) step();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
